// File: rtl/spram_arb.sv
// spram_arb: two-requester arbiter in front of one 16k x 32 byte-writable SPRAM.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   m0_* / m1_*                 requester ports (CPU / SPI-DMA):
//     mX_valid, mX_we, mX_addr, mX_wdat   request in (we == 0 means read)
//     mX_ready                            combinational accept for this cycle
//     mX_rdat, mX_rvalid                  read return, 2 cycles after accept
//   ram_sel, ram_we, ram_addr,
//   ram_wdat                    registered RAM control bus
//   ram_rdat                    RAM read data, valid the cycle after the access edge
//
// Build option: define SPRAM_ARB_PRIO_EN for fixed priority (m0 wins ties)
// with an m1 starvation counter bounded by STARVE_MAX. Without it,
// arbitration is round-robin on ties.
module spram_arb #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [DW/8-1:0]   m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdat,
    output logic [DW-1:0]     m0_rdat,
    output logic              m0_rvalid,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [DW/8-1:0]   m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdat,
    output logic [DW-1:0]     m1_rdat,
    output logic              m1_rvalid,

    output logic              ram_sel,
    output logic [DW/8-1:0]   ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdat,
    input  logic [DW-1:0]     ram_rdat
);

    localparam int unsigned BW = DW / 8;

    logic          gnt0;
    logic          gnt1;
    logic          tie_m1;
    logic          acc;

    logic          ram_sel_q,  ram_sel_d;
    logic [BW-1:0] ram_we_q,   ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdat_q, ram_wdat_d;

    // Tag stage 1: a read is in flight, and which port issued it.
    logic          tag_vld_q,  tag_vld_d;
    logic          tag_id_q,   tag_id_d;
    // Tag stage 2: per-port return strobes.
    logic          rvalid0_q,  rvalid0_d;
    logic          rvalid1_q,  rvalid1_d;

`ifdef SPRAM_ARB_PRIO_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q, starve_d;

    // m1 takes the tie only after STARVE_MAX consecutive losses.
    always_comb begin
        tie_m1 = (starve_q >= CW'(STARVE_MAX));
    end

    // Counts cycles m1 waits behind m0; any m1 grant or idle m1 clears it.
    always_comb begin
        starve_d = starve_q;
        if (!m1_valid || gnt1) begin
            starve_d = '0;
        end else if (starve_q < CW'(STARVE_MAX)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // 1 = m1 was served last; resets to m1 so m0 takes the first tie.
    logic last_q, last_d;

    always_comb begin
        tie_m1 = ~last_q;
    end

    // Pointer moves only when a request is actually accepted.
    always_comb begin
        last_d = last_q;
        if (acc) begin
            last_d = gnt1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Grant: a lone requester wins; on a tie, tie_m1 decides.
    always_comb begin
        gnt1 = m1_valid & (~m0_valid | tie_m1);
        gnt0 = m0_valid & ~gnt1;
        acc  = gnt0 | gnt1;
    end

    assign m0_ready = gnt0;
    assign m1_ready = gnt1;

    // Next RAM bus and tag state; addr/wdat hold while idle.
    always_comb begin
        ram_sel_d  = acc;
        ram_we_d   = '0;
        ram_addr_d = ram_addr_q;
        ram_wdat_d = ram_wdat_q;
        tag_vld_d  = 1'b0;
        tag_id_d   = 1'b0;
        rvalid0_d  = tag_vld_q & ~tag_id_q;
        rvalid1_d  = tag_vld_q &  tag_id_q;
        if (gnt1) begin
            ram_we_d   = m1_we;
            ram_addr_d = m1_addr;
            ram_wdat_d = m1_wdat;
            tag_vld_d  = (m1_we == '0);
            tag_id_d   = 1'b1;
        end else if (gnt0) begin
            ram_we_d   = m0_we;
            ram_addr_d = m0_addr;
            ram_wdat_d = m0_wdat;
            tag_vld_d  = (m0_we == '0);
            tag_id_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_sel_q  <= 1'b0;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_wdat_q <= '0;
            tag_vld_q  <= 1'b0;
            tag_id_q   <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            ram_sel_q  <= ram_sel_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_wdat_q <= ram_wdat_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign ram_sel   = ram_sel_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdat  = ram_wdat_q;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    // Read data is shared; the rvalid strobes say whose it is.
    assign m0_rdat   = ram_rdat;
    assign m1_rdat   = ram_rdat;

endmodule

// File: tb/tb_spram_arb.sv
// Directed self-checking bench for spram_arb with a behavioural SPRAM model.
module tb_spram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [3:0]  m0_we, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdat, m1_wdat;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_rvalid, m1_rvalid;
    logic        ram_sel;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat;

    int n_chk = 0;
    int n_err = 0;

    localparam int NRR = 18;
    logic exp_g1 [0:NRR-1];

    always #5 clk = ~clk;

    spram_arb #(.AW(16), .DW(32), .STARVE_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdat   (m0_wdat),
        .m0_rdat   (m0_rdat),
        .m0_rvalid (m0_rvalid),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdat   (m1_wdat),
        .m1_rdat   (m1_rdat),
        .m1_rvalid (m1_rvalid),
        .ram_sel   (ram_sel),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdat  (ram_wdat),
        .ram_rdat  (ram_rdat)
    );

    // SPRAM model: read-before-write, data out the cycle after the access edge.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[4]   <= 32'hDEADBEEF;
            mem[8]   <= 32'hAAAAAAAA;
            mem[16]  <= 32'h11111111;
            mem[32]  <= 32'h22222222;
            ram_rdat <= 32'h0;
        end else if (ram_sel) begin
            ram_rdat <= mem[ram_addr[15:2]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr[15:2]][b*8 +: 8] <= ram_wdat[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_we = 4'h0; m0_addr = 16'h0; m0_wdat = 32'h0;
        m1_valid = 1'b0; m1_we = 4'h0; m1_addr = 16'h0; m1_wdat = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_sel", ram_sel, 1'b0);
        chk("rst_we", ram_we, 4'h0);
        chk("rst_addr", ram_addr, 16'h0);
        chk("rst_wdat", ram_wdat, 32'h0);
        chk("rst_rv0", m0_rvalid, 1'b0);
        chk("rst_rv1", m1_rvalid, 1'b0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // m0 read of word 4
        m0_valid = 1'b1; m0_addr = 16'h0010;
        @(negedge clk);
        chk("t1_m0_ready", m0_ready, 1'b1);
        chk("t1_m1_ready", m1_ready, 1'b0);
        chk("t1_sel_c0", ram_sel, 1'b0);
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk("t1_sel_c1", ram_sel, 1'b1);
        chk("t1_we_c1", ram_we, 4'h0);
        chk("t1_addr_c1", ram_addr, 16'h0010);
        chk("t1_rv0_c1", m0_rvalid, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("t1_rv0_c2", m0_rvalid, 1'b1);
        chk("t1_rdat_c2", m0_rdat, 32'hDEADBEEF);
        chk("t1_rv1_c2", m1_rvalid, 1'b0);
        chk("t1_sel_c2", ram_sel, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("t1_rv0_c3", m0_rvalid, 1'b0);
        next_cyc();

        // m1 partial write then read back
        m1_valid = 1'b1; m1_we = 4'b0011; m1_addr = 16'h0020; m1_wdat = 32'h12345678;
        @(negedge clk);
        chk("t2_m1_ready_w", m1_ready, 1'b1);
        chk("t2_m0_ready_w", m0_ready, 1'b0);
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk("t2_sel_w", ram_sel, 1'b1);
        chk("t2_we_w", ram_we, 4'b0011);
        chk("t2_addr_w", ram_addr, 16'h0020);
        chk("t2_wdat_w", ram_wdat, 32'h12345678);
        next_cyc();
        m1_valid = 1'b1; m1_we = 4'b0000; m1_addr = 16'h0020;
        @(negedge clk);
        chk("t2_rv1_w", m1_rvalid, 1'b0);
        chk("t2_m1_ready_r", m1_ready, 1'b1);
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk("t2_rv1_w2", m1_rvalid, 1'b0);
        chk("t2_we_r", ram_we, 4'h0);
        next_cyc();
        @(negedge clk);
        chk("t2_rv1_r", m1_rvalid, 1'b1);
        chk("t2_rv0_r", m0_rvalid, 1'b0);
        chk("t2_rdat_r", m1_rdat, 32'hAAAA5678);
        next_cyc();

        // both requesters reading continuously
        m0_valid = 1'b1; m0_addr = 16'h0040;
        m1_valid = 1'b1; m1_addr = 16'h0080;
        for (int k = 0; k < NRR + 2; k++) begin
            if (k == NRR) idle_inputs();
            @(negedge clk);
            if (k < NRR) begin
`ifdef SPRAM_ARB_PRIO_EN
                exp_g1[k] = ((k % 9) == 8);
`else
                exp_g1[k] = ((k % 2) == 1);
`endif
                chk("rr_m0_ready", m0_ready, !exp_g1[k]);
                chk("rr_m1_ready", m1_ready, exp_g1[k]);
            end
            if (k >= 2) begin
                chk("rr_m0_rvalid", m0_rvalid, !exp_g1[k-2]);
                chk("rr_m1_rvalid", m1_rvalid, exp_g1[k-2]);
                chk("rr_rdat", m0_rdat, exp_g1[k-2] ? 32'h22222222 : 32'h11111111);
            end
            next_cyc();
        end
        @(negedge clk);
        chk("rr_drain_rv0", m0_rvalid, 1'b0);
        chk("rr_drain_rv1", m1_rvalid, 1'b0);
        next_cyc();

        // reset one cycle after an m1 read is accepted
        m1_valid = 1'b1; m1_addr = 16'h0080;
        @(negedge clk);
        chk("t4_m1_ready", m1_ready, 1'b1);
        next_cyc();
        idle_inputs();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_rst_sel", ram_sel, 1'b0);
            chk("t4_rst_addr", ram_addr, 16'h0);
            chk("t4_rst_rv1", m1_rvalid, 1'b0);
            chk("t4_rst_rdy", {m0_ready, m1_ready}, 2'b00);
            next_cyc();
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_post_rv1", m1_rvalid, 1'b0);
        next_cyc();
        m0_valid = 1'b1; m0_addr = 16'h0044;
        m1_valid = 1'b1; m1_addr = 16'h0080;
        @(negedge clk);
        chk("t4_tie_m0", m0_ready, 1'b1);
        chk("t4_tie_m1", m1_ready, 1'b0);
        next_cyc();
        idle_inputs();
        next_cyc();
        @(negedge clk);
        chk("t4_tie_rv0", m0_rvalid, 1'b1);
        next_cyc();
        next_cyc();

        // idle with junk on the request buses
        m0_we = 4'hF; m0_addr = 16'h1234; m0_wdat = 32'hFFFFFFFF;
        m1_we = 4'hF; m1_addr = 16'h5678; m1_wdat = 32'hFFFFFFFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_sel", ram_sel, 1'b0);
            chk("idle_we", ram_we, 4'h0);
            chk("idle_addr_hold", ram_addr, 16'h0044);
            chk("idle_rdy", {m0_ready, m1_ready}, 2'b00);
            chk("idle_rv", {m0_rvalid, m1_rvalid}, 2'b00);
            next_cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
